// File: rtl/keypad_scan_debounce_if.sv
// Keypad-side and core-side signals of the 4x6 calculator keypad scanner.
// master = the scanner itself, slave = the board/consumer view.
interface keypad_scan_debounce_if;
  logic [5:0] kpcol;
  logic [3:0] kprow;
  logic       newkey;
  logic [4:0] keycode;

  modport master (input kpcol, output kprow, newkey, keycode);
  modport slave  (output kpcol, input kprow, newkey, keycode);
endinterface

// File: rtl/keypad_scan_debounce.sv
// 4x6 keypad row scanner with full-scan debouncing; one newkey pulse per accepted press.
// Optional auto-repeat while a single key is held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scan_debounce #(
  parameter int SCAN_DIV       = 5000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 500,
  parameter int REPEAT_RATE    = 100
) (
  input  logic clk,
  input  logic rstn,
  keypad_scan_debounce_if.master kp
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);

  if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("keypad_scan_debounce: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, CAND, PRESSED} state_t;
  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} result_t;

  logic [5:0]    col_meta, col_sync;
  logic [SW-1:0] slot_cnt;
  logic [1:0]    row_idx;
  logic          slot_end, scan_done;

  logic [2:0]    row_hits;
  logic [2:0]    row_col;
  logic [4:0]    row_code;
  result_t       prev_kind, scan_kind, acc_kind;
  logic [4:0]    scan_code, acc_code;

  state_t        state, state_nx;
  logic [DW-1:0] cnt, cnt_nx;
  logic [4:0]    cand, cand_nx;
  logic          fire;
  logic          newkey_q;
  logic [4:0]    keycode_q;

  // Idle columns read high, so the synchroniser resets to all-ones: nothing looks pressed.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: state elements use non-blocking assignments so every flop sees pre-edge values.
    if (!rstn) begin
      col_meta <= 6'h3F;
      col_sync <= 6'h3F;
    end else begin
      col_meta <= kp.kpcol;
      col_sync <= col_meta;
    end
  end

  assign slot_end  = (slot_cnt == SW'(SCAN_DIV - 1));
  assign scan_done = slot_end && (row_idx == 2'd3);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_cnt <= '0;
      row_idx  <= 2'd0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      row_idx  <= row_idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
    end
  end

  // Per-row decode merged into the running scan result; row 0 starts a fresh scan.
  always_comb begin
    row_hits = 3'd0;
    row_col  = 3'd0;
    for (int c = 0; c < 6; c++) begin
      if (!col_sync[c]) begin
        row_hits = row_hits + 3'd1;
        row_col  = 3'(c);
      end
    end
    row_code  = ({3'b000, row_idx} * 5'd6) + {2'b00, row_col};
    prev_kind = (row_idx == 2'd0) ? RES_NONE : acc_kind;
    scan_kind = prev_kind;
    scan_code = acc_code;
    if (row_hits == 3'd1 && prev_kind == RES_NONE) begin
      scan_kind = RES_SINGLE;
      scan_code = row_code;
    end else if (row_hits != 3'd0) begin
      scan_kind = RES_MULTI;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_kind <= RES_NONE;
      acc_code <= 5'd0;
    end else if (slot_end) begin
      acc_kind <= scan_kind;
      acc_code <= scan_code;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0] rep_cnt, rep_cnt_nx, rep_target;
  logic          rep_first, rep_first_nx;
`endif

  always_comb begin
    // NOTE: defaults first, so no path through the case below can infer a latch.
    state_nx = state;
    cnt_nx   = cnt;
    cand_nx  = cand;
    fire     = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_nx   = rep_cnt;
    rep_first_nx = rep_first;
    rep_target   = rep_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
`endif
    if (scan_done) begin
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_nx   = '0;
      rep_first_nx = 1'b1;
`endif
      unique case (state)
        IDLE: begin
          if (scan_kind == RES_SINGLE) begin
            cand_nx = scan_code;
            if (DEBOUNCE_SCANS == 1) begin
              state_nx = PRESSED;
              cnt_nx   = '0;
              fire     = 1'b1;
            end else begin
              state_nx = CAND;
              cnt_nx   = DW'(1);
            end
          end
        end
        CAND: begin
          if (scan_kind == RES_SINGLE && scan_code == cand) begin
            if (cnt == DW'(DEBOUNCE_SCANS - 1)) begin
              state_nx = PRESSED;
              cnt_nx   = '0;
              fire     = 1'b1;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end else if (scan_kind == RES_SINGLE) begin
            cand_nx = scan_code;
            cnt_nx  = DW'(1);
          end else begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end
        PRESSED: begin
          if (scan_kind == RES_NONE) begin
            if (cnt == DW'(DEBOUNCE_SCANS - 1)) begin
              state_nx = IDLE;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end else begin
            cnt_nx = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
            if (scan_kind == RES_SINGLE && scan_code == cand) begin
              if (rep_cnt + 1'b1 == rep_target) begin
                fire         = 1'b1;
                rep_first_nx = 1'b0;
              end else begin
                rep_cnt_nx   = rep_cnt + 1'b1;
                rep_first_nx = rep_first;
              end
            end
`endif
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= 5'd0;
      newkey_q  <= 1'b0;
      keycode_q <= 5'd0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      cand     <= cand_nx;
      newkey_q <= fire;
      if (fire) keycode_q <= scan_code;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt_nx;
      rep_first <= rep_first_nx;
    end
  end
`endif

  assign kp.kprow   = ~(4'b0001 << row_idx);
  assign kp.newkey  = newkey_q;
  assign kp.keycode = keycode_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a 24-key switch matrix drives the columns, and a
// scan-level reference model predicts every newkey/keycode/kprow value cycle by cycle.
module tb_keypad_scan_debounce;

  localparam int SCAN_DIV = 4;
  localparam int DB       = 3;
  localparam int RD       = 5;
  localparam int RR       = 2;
  localparam int SCAN_CYC = 4 * SCAN_DIV;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  keypad_scan_debounce_if kp_bus ();

  // Switch matrix: bit (row*6 + col) set means that key is held down.
  logic [23:0] matrix = '0;
  logic [5:0]  kp_cols;

  always_comb begin
    kp_cols = 6'h3F;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 6; c++)
        if (!kp_bus.kprow[r] && matrix[r*6 + c]) kp_cols[c] = 1'b0;
  end
  assign kp_bus.kpcol = kp_cols;

  keypad_scan_debounce #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DB),
    .REPEAT_DELAY  (RD),
    .REPEAT_RATE   (RR)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .kp  (kp_bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d after reset)", tag, got, exp, cyc);
    end
  endtask

  // Reference model, one step per full scan of a constant matrix.
  bit m_pressed;
  int m_run_len, m_run_code, m_none_run, m_held, m_rep, m_keycode;
  bit m_rep_first;

  task automatic model_reset();
    m_pressed   = 0;
    m_run_len   = 0;
    m_run_code  = 0;
    m_none_run  = 0;
    m_held      = 0;
    m_rep       = 0;
    m_rep_first = 1;
    m_keycode   = 0;
  endtask

  task automatic model_scan(input logic [23:0] m, output bit fire, output int code);
    int n, idx;
    n = $countones(m);
    idx = 0;
    for (int k = 0; k < 24; k++) if (m[k]) idx = k;
    fire = 0;
    code = idx;
    if (!m_pressed) begin
      if (n == 1) begin
        if (m_run_len > 0 && idx == m_run_code) m_run_len++;
        else begin
          m_run_code = idx;
          m_run_len  = 1;
        end
        if (m_run_len == DB) begin
          fire        = 1;
          m_pressed   = 1;
          m_held      = idx;
          m_none_run  = 0;
          m_rep       = 0;
          m_rep_first = 1;
        end
      end else begin
        m_run_len = 0;
      end
    end else begin
      if (n == 0) begin
        m_none_run++;
        if (m_none_run == DB) begin
          m_pressed = 0;
          m_run_len = 0;
        end
      end else begin
        m_none_run = 0;
      end
`ifdef KEYPAD_AUTOREPEAT_EN
      if (n == 1 && idx == m_held) begin
        m_rep++;
        if (m_rep == (m_rep_first ? RD : RR)) begin
          fire        = 1;
          m_rep       = 0;
          m_rep_first = 0;
        end
      end else begin
        m_rep       = 0;
        m_rep_first = 1;
      end
`endif
    end
  endtask

  // Holds the matrix for ncyc cycles starting at a scan boundary; a full scan is also
  // fed to the model, whose decision shows up on the first cycle of the next scan.
  task automatic run_scan(input logic [23:0] m, input int ncyc, output bit pulsed);
    bit f;
    int code;
    logic [3:0] exp_row;
    matrix = m;
    f = 0;
    code = 0;
    if (ncyc == SCAN_CYC) model_scan(m, f, code);
    pulsed = 0;
    for (int i = 1; i <= ncyc; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      exp_row = 4'hF ^ (4'b0001 << ((cyc / SCAN_DIV) % 4));
      check("kprow", kp_bus.kprow, exp_row);
      if (i == SCAN_CYC && f) m_keycode = code;
      check("newkey", kp_bus.newkey, (i == SCAN_CYC && f) ? 1 : 0);
      check("keycode", kp_bus.keycode, m_keycode);
      if (kp_bus.newkey === 1'b1) pulsed = 1;
    end
  endtask

  task automatic run_phase(input logic [23:0] m, input int nscans,
                           output int npulses, output int first_idx);
    bit p;
    npulses   = 0;
    first_idx = 0;
    for (int s = 1; s <= nscans; s++) begin
      run_scan(m, SCAN_CYC, p);
      if (p) begin
        npulses++;
        if (first_idx == 0) first_idx = s;
      end
    end
  endtask

  // Called at a point just after a clock edge; releases reset just after an edge too.
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    check("rst_kprow", kp_bus.kprow, 4'hE);
    check("rst_newkey", kp_bus.newkey, 0);
    check("rst_keycode", kp_bus.keycode, 0);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    cyc = 0;
    model_reset();
  endtask

  function automatic logic [23:0] key(input int code);
    logic [23:0] v;
    v = '0;
    v[code] = 1'b1;
    return v;
  endfunction

  initial begin
    int np, fi, tot, hold, sel;
    bit p;
    logic [23:0] m;
    model_reset();
    do_reset();

    run_phase('0, 3, np, fi);
    check("idle_pulses", np, 0);

    // Clean press of row2/col3, held 20 scans.
    run_phase(key(15), 20, np, fi);
`ifdef KEYPAD_AUTOREPEAT_EN
    check("clean_pulses", np, 8);
`else
    check("clean_pulses", np, 1);
`endif
    check("clean_first_scan", fi, 3);
    check("clean_code", kp_bus.keycode, 15);
    run_phase('0, 5, np, fi);
    check("clean_release", np, 0);

    // Bounce row0/col0 every scan for 10 scans, then hold it.
    tot = 0;
    for (int s = 0; s < 10; s++) begin
      run_scan((s % 2 == 0) ? key(0) : 24'h0, SCAN_CYC, p);
      if (p) tot++;
    end
    check("bounce_pulses", tot, 0);
    run_phase(key(0), 6, np, fi);
    check("bounce_hold_first", fi, 3);
    check("bounce_code", kp_bus.keycode, 0);
    run_phase('0, 5, np, fi);

    // Two keys in different rows, then release one.
    run_phase(key(8) | key(23), 10, np, fi);
    check("multi_pulses", np, 0);
    run_phase(key(8), 5, np, fi);
    check("multi_release_pulses", np, 1);
    check("multi_release_code", kp_bus.keycode, 8);
    run_phase('0, 5, np, fi);

    // Release/re-press with full-length gaps, then with a gap too short to release.
    tot = 0;
    for (int k = 0; k < 2; k++) begin
      run_phase(key(23), 6, np, fi);
      tot += np;
      run_phase('0, 6, np, fi);
    end
    check("repress_pulses", tot, 2);
    check("repress_code", kp_bus.keycode, 23);
    tot = 0;
    run_phase(key(23), 6, np, fi); tot += np;
    run_phase('0, 2, np, fi);      tot += np;
    run_phase(key(23), 6, np, fi); tot += np;
    run_phase('0, 6, np, fi);
    check("short_gap_pulses", tot, 1);

    // Reset while two agreeing scans are already counted, key still held afterwards.
    run_phase(key(15), 2, np, fi);
    run_scan(key(15), 7, p);
    do_reset();
    run_phase(key(15), 5, np, fi);
    check("rst_mid_first", fi, 3);
    check("rst_mid_pulses", np, 1);
    run_phase('0, 5, np, fi);

    // Random patterns: quiet, single keys (often repeated) and multi-key chords.
    for (int seg = 0; seg < 120; seg++) begin
      sel  = $urandom_range(0, 9);
      hold = $urandom_range(1, 6);
      if (sel < 3) m = '0;
      else if (sel < 8) m = key($urandom_range(0, 3) == 0 ? 15 : $urandom_range(0, 23));
      else m = key($urandom_range(0, 11)) | key($urandom_range(12, 23));
      run_phase(m, hold, np, fi);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
